// File: rtl/stack_dump.sv
// ----------------------------------------------------------------------------
// stack_dump -- ring-buffer operand stack with a streaming dump port.
//
// The CPU side pushes, drops and overwrites entries of a DEPTH-entry ring
// addressed by a wrapping stack pointer. The top two entries are always
// visible on rd1/rd2. On request, the dump port streams the valid entries
// from top to deepest over a valid/ready handshake. While a dump is in
// progress the CPU side is ignored.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   we, delta, wd  CPU op: delta 00 hold, 01 push, 10 drop two, 11 drop one;
//                  we writes wd into the (new) top
//   rd1, rd2       top and second entry
//   depth          valid-entry count, 0..DEPTH (saturating)
//   dump_req       one-cycle request to start a dump
//   dump_busy      dump in progress
//   dump_valid/dump_ready/dump_data/dump_last  dump stream handshake
//   ovf, unf       sticky overflow / underflow flags
//
// Configuration macro: STACK_DUMP_FLAGS_EN -- when defined, ovf/unf are
// live sticky flags; when undefined they are tied to 0.
// ----------------------------------------------------------------------------
module stack_dump #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [1:0]                 delta,
    input  logic [WIDTH-1:0]           wd,
    output logic [WIDTH-1:0]           rd1,
    output logic [WIDTH-1:0]           rd2,
    output logic [$clog2(DEPTH):0]     depth,
    input  logic                       dump_req,
    output logic                       dump_busy,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic [WIDTH-1:0]           dump_data,
    output logic                       dump_last,
    output logic                       ovf,
    output logic                       unf
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   ONE     = AW'(1);

    typedef enum logic {IDLE, SEND} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  ring_q [DEPTH];
    logic [AW-1:0]     sp_q, sp_d;
    logic [AW:0]       depth_q, depth_d;
    logic [AW-1:0]     k_q;
    logic [AW:0]       count_q;
    logic              dump_valid_q;

    logic              wr_en;
    logic [AW-1:0]     wr_idx;
    logic [WIDTH-1:0]  wr_data;
    logic              dump_start;
    logic              cpu_en;
    logic              at_last;
    logic [AW-1:0]     dump_idx;

    // The accepting cycle also suppresses the CPU op, so the captured count
    // and the pointer used for streaming describe the same stack image.
    assign dump_start = (state_q == IDLE) && dump_req && (depth_q != '0);
    assign cpu_en     = (state_q == IDLE) && !dump_start;

    // CPU-side next state. Drops never clear the ring, so wrapped entries
    // reappear when the pointer moves back over them.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        sp_d    = sp_q;
        depth_d = depth_q;
        wr_en   = 1'b0;
        wr_idx  = sp_q;
        wr_data = wd;
        unique case (delta)
            2'b00: begin
                wr_en = we;
            end
            2'b01: begin
                sp_d    = sp_q + ONE;
                wr_idx  = sp_q + ONE;
                wr_en   = 1'b1;
                wr_data = we ? wd : ring_q[sp_q];
                // A full stack overwrites its oldest entry; the count stays put.
                depth_d = (depth_q == DEPTH_C) ? depth_q : depth_q + 1'b1;
            end
            2'b11: begin
                sp_d    = sp_q - ONE;
                wr_idx  = sp_q - ONE;
                wr_en   = we;
                depth_d = (depth_q == '0) ? '0 : depth_q - 1'b1;
            end
            default: begin
                sp_d    = sp_q - AW'(2);
                wr_idx  = sp_q - AW'(2);
                wr_en   = we;
                depth_d = (depth_q < (AW+1)'(2)) ? '0 : depth_q - (AW+1)'(2);
            end
        endcase
    end

    // Storage, pointer and dump FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sp_q         <= '0;
            depth_q      <= '0;
            k_q          <= '0;
            count_q      <= '0;
            dump_valid_q <= 1'b0;
            // NOTE: the ring is reset entry by entry because rd1/rd2 and the
            // dump stream must read zero straight out of reset; this keeps the
            // storage in flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                ring_q[i] <= '0;
            end
        end else begin
            // NOTE: state updates use non-blocking assignments so every
            // register samples the pre-edge values regardless of order.
            if (cpu_en) begin
                sp_q    <= sp_d;
                depth_q <= depth_d;
                if (wr_en) begin
                    ring_q[wr_idx] <= wr_data;
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (dump_start) begin
                        state_q      <= SEND;
                        dump_valid_q <= 1'b1;
                        k_q          <= '0;
                        count_q      <= depth_q;
                    end
                end
                SEND: begin
                    if (dump_valid_q && dump_ready) begin
                        if (at_last) begin
                            state_q      <= IDLE;
                            dump_valid_q <= 1'b0;
                        end else begin
                            k_q <= k_q + ONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign at_last    = ({1'b0, k_q} == (count_q - 1'b1));
    assign dump_idx   = sp_q - k_q;

    assign rd1        = ring_q[sp_q];
    assign rd2        = ring_q[sp_q - ONE];
    assign depth      = depth_q;
    assign dump_busy  = (state_q == SEND);
    assign dump_valid = dump_valid_q;
    assign dump_data  = dump_valid_q ? ring_q[dump_idx] : '0;
    assign dump_last  = dump_valid_q && at_last;

`ifdef STACK_DUMP_FLAGS_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (cpu_en) begin
            if ((delta == 2'b01) && (depth_q == DEPTH_C)) begin
                ovf_q <= 1'b1;
            end
            if (((delta == 2'b11) && (depth_q == '0)) ||
                ((delta == 2'b10) && (depth_q < (AW+1)'(2)))) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_stack_dump.sv
// ----------------------------------------------------------------------------
// tb_stack_dump -- directed self-checking bench for stack_dump (DEPTH=16,
// WIDTH=16). Inputs change 1 time unit after a rising edge and outputs are
// sampled at that point, so each step observes the result of one edge.
// ----------------------------------------------------------------------------
module tb_stack_dump;

    localparam int DEPTH = 16;
    localparam int WIDTH = 16;

`ifdef STACK_DUMP_FLAGS_EN
    localparam logic FLAGS = 1'b1;
`else
    localparam logic FLAGS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic [1:0]        delta;
    logic [WIDTH-1:0]  wd;
    logic [WIDTH-1:0]  rd1, rd2;
    logic [4:0]        depth;
    logic              dump_req, dump_busy, dump_valid, dump_ready;
    logic [WIDTH-1:0]  dump_data;
    logic              dump_last, ovf, unf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stack_dump #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .delta      (delta),
        .wd         (wd),
        .rd1        (rd1),
        .rd2        (rd2),
        .depth      (depth),
        .dump_req   (dump_req),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .ovf        (ovf),
        .unf        (unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; delta = 2'b00; wd = '0; dump_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        dump_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic cpu_op(input logic [1:0] d, input logic w, input logic [WIDTH-1:0] data);
        delta = d; we = w; wd = data;
        tick();
        idle_inputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".rd1"},   32'(rd1), 32'h0);
        check({tag, ".rd2"},   32'(rd2), 32'h0);
        check({tag, ".depth"}, 32'(depth), 32'h0);
        check({tag, ".busy"},  32'(dump_busy), 32'h0);
        check({tag, ".valid"}, 32'(dump_valid), 32'h0);
        check({tag, ".last"},  32'(dump_last), 32'h0);
        check({tag, ".data"},  32'(dump_data), 32'h0);
        check({tag, ".ovf"},   32'(ovf), 32'h0);
        check({tag, ".unf"},   32'(unf), 32'h0);
    endtask

    initial begin
        // Reset state.
        do_reset();
        check_reset_outputs("reset");

        // Three pushes with write data.
        cpu_op(2'b01, 1'b1, 16'h1111);
        cpu_op(2'b01, 1'b1, 16'h2222);
        cpu_op(2'b01, 1'b1, 16'h3333);
        check("push3.rd1",   32'(rd1), 32'h3333);
        check("push3.rd2",   32'(rd2), 32'h2222);
        check("push3.depth", 32'(depth), 32'd3);

        // Back-to-back dump with ready held high.
        dump_ready = 1'b1;
        dump_req   = 1'b1;
        tick();
        dump_req   = 1'b0;
        check("dump0.valid", 32'(dump_valid), 32'h1);
        check("dump0.busy",  32'(dump_busy), 32'h1);
        check("dump0.data",  32'(dump_data), 32'h3333);
        check("dump0.last",  32'(dump_last), 32'h0);
        tick();
        check("dump1.data",  32'(dump_data), 32'h2222);
        check("dump1.last",  32'(dump_last), 32'h0);
        tick();
        check("dump2.data",  32'(dump_data), 32'h1111);
        check("dump2.last",  32'(dump_last), 32'h1);
        tick();
        check("dump_end.busy",  32'(dump_busy), 32'h0);
        check("dump_end.valid", 32'(dump_valid), 32'h0);
        check("dump_end.depth", 32'(depth), 32'd3);

        // Dump with a 4-cycle stall mid-stream and a push attempted in SEND.
        dump_ready = 1'b0;
        dump_req   = 1'b1;
        tick();
        dump_req   = 1'b0;
        check("stall.first", 32'(dump_data), 32'h3333);
        dump_ready = 1'b1;
        tick();
        check("stall.second", 32'(dump_data), 32'h2222);
        dump_ready = 1'b0;
        delta = 2'b01; we = 1'b1; wd = 16'hABCD;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("stall.hold%0d", i), 32'(dump_data), 32'h2222);
            check($sformatf("stall.valid%0d", i), 32'(dump_valid), 32'h1);
        end
        idle_inputs();
        dump_ready = 1'b1;
        tick();
        check("stall.third", 32'(dump_data), 32'h1111);
        check("stall.last",  32'(dump_last), 32'h1);
        tick();
        check("stall.idle",  32'(dump_busy), 32'h0);
        check("stall.depth", 32'(depth), 32'd3);
        check("stall.rd1",   32'(rd1), 32'h3333);

        // Drop one with write, push without write (copy), hold with write.
        cpu_op(2'b11, 1'b1, 16'h4444);
        check("drop1w.rd1",   32'(rd1), 32'h4444);
        check("drop1w.rd2",   32'(rd2), 32'h1111);
        check("drop1w.depth", 32'(depth), 32'd2);
        cpu_op(2'b01, 1'b0, 16'h9999);
        check("pushcopy.rd1",   32'(rd1), 32'h4444);
        check("pushcopy.rd2",   32'(rd2), 32'h4444);
        check("pushcopy.depth", 32'(depth), 32'd3);
        cpu_op(2'b00, 1'b1, 16'h5555);
        check("holdw.rd1",   32'(rd1), 32'h5555);
        check("holdw.rd2",   32'(rd2), 32'h4444);
        check("holdw.depth", 32'(depth), 32'd3);

        // Overflow: 17 pushes into a 16-deep stack.
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            cpu_op(2'b01, 1'b1, WIDTH'(i));
            if (i == 16) check("ovf.before", 32'(ovf), 32'h0);
        end
        check("ovf.depth", 32'(depth), 32'd16);
        check("ovf.rd1",   32'(rd1), 32'd17);
        check("ovf.rd2",   32'(rd2), 32'd16);
        check("ovf.flag",  32'(ovf), 32'(FLAGS));
        dump_ready = 1'b1;
        dump_req   = 1'b1;
        tick();
        dump_req   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovf.dump%0d", i), 32'(dump_data), 32'(17 - i));
            check($sformatf("ovf.last%0d", i), 32'(dump_last), 32'(i == 15));
            tick();
        end
        check("ovf.dump_end", 32'(dump_valid), 32'h0);

        // Underflow: drop two from depth 1, then a dump request is ignored.
        do_reset();
        cpu_op(2'b01, 1'b1, 16'h0055);
        check("unf.depth1", 32'(depth), 32'd1);
        check("unf.before", 32'(unf), 32'h0);
        cpu_op(2'b10, 1'b0, 16'h0000);
        check("unf.depth0", 32'(depth), 32'd0);
        check("unf.flag",   32'(unf), 32'(FLAGS));
        dump_ready = 1'b1;
        dump_req   = 1'b1;
        tick();
        dump_req   = 1'b0;
        check("unf.nodump.busy",  32'(dump_busy), 32'h0);
        check("unf.nodump.valid", 32'(dump_valid), 32'h0);
        tick();
        check("unf.nodump.busy2", 32'(dump_busy), 32'h0);

        // Reset asserted mid-dump after one transfer.
        do_reset();
        cpu_op(2'b01, 1'b1, 16'hA001);
        cpu_op(2'b01, 1'b1, 16'hA002);
        cpu_op(2'b01, 1'b1, 16'hA003);
        dump_ready = 1'b1;
        dump_req   = 1'b1;
        tick();
        dump_req   = 1'b0;
        check("rstdump.first", 32'(dump_data), 32'hA003);
        tick();
        check("rstdump.second", 32'(dump_data), 32'hA002);
        rst = 1'b1;
        #1;
        check_reset_outputs("rstdump.async");
        tick();
        check("rstdump.held.valid", 32'(dump_valid), 32'h0);
        rst = 1'b0;
        tick();
        check("rstdump.after.valid", 32'(dump_valid), 32'h0);
        check("rstdump.after.busy",  32'(dump_busy), 32'h0);
        check("rstdump.after.depth", 32'(depth), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_dump.md
STACK_DUMP -- requirements
Module: stack_dump

Interface
REQ-001 Parameter DEPTH, default 16, number of stack entries (power of two, 4..64).
REQ-002 Parameter WIDTH, default 16, bits per entry (multiple of 8).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 we  input  1  CPU side: write wd into new top this cycle.
REQ-006 delta  input  2  CPU side: 00 hold, 01 push, 10 drop two, 11 drop one.
REQ-007 wd  input  WIDTH  CPU side write data.
REQ-008 rd1  output  WIDTH  top of stack; rd2  output  WIDTH  second entry.
REQ-009 depth  output  $clog2(DEPTH)+1  current valid-entry count, 0..DEPTH.
REQ-010 dump_req  input  1  one-cycle request to stream the stack out.
REQ-011 dump_busy  output  1  dump in progress; CPU side is ignored.
REQ-012 dump_valid, dump_ready  output/input  1 each  dump handshake.
REQ-013 dump_data  output  WIDTH; dump_last  output  1  marks deepest entry.
REQ-014 ovf, unf  output  1 each  sticky overflow/underflow flags.

Function
REQ-015 Storage SHALL be a DEPTH-entry ring indexed by pointer sp (mod DEPTH); rd1 = ring[sp], rd2 = ring[sp-1], combinational from registers.
REQ-016 Hold: sp unchanged; we=1 writes wd to ring[sp].
REQ-017 Push: sp+1; new top gets wd if we=1, else copy of old top.
REQ-018 Drop one: sp-1; drop two: sp-2; if we=1, wd overwrites the new top.
REQ-019 Underlying ring contents SHALL NOT be cleared on pops; wrapped entries reappear.
REQ-020 depth SHALL track pushes/pops, saturating at DEPTH on push and at 0 on pop.
REQ-021 Push at depth==DEPTH SHALL overwrite the oldest entry, depth stays DEPTH.
REQ-022 Pop of more entries than depth SHALL clamp depth to 0; sp still moves.
REQ-023 FSM states IDLE, SEND; dump_busy = (state==SEND).
REQ-024 IDLE -> SEND on dump_req=1 with depth>0; dump_req at depth 0 or in SEND ignored.
REQ-025 Accepting edge captures index k=0 and count=depth; dump_valid=1 from next cycle.
REQ-026 dump_data = ring[sp-k]; dump_last = (k==count-1); both stable while valid and not ready.
REQ-027 Transfer on dump_valid & dump_ready: k+1; after last transfer, state IDLE, dump_valid=0 next cycle.
REQ-028 While in SEND, we/delta SHALL be ignored; sp, depth, ring unchanged.
REQ-029 One transfer per cycle max; back-to-back transfers with dump_ready held high.

Reset
REQ-030 rst=1 SHALL immediately force sp=0, depth=0, all ring entries 0, state IDLE.
REQ-031 During/after reset: rd1=rd2=0, dump_busy=0, dump_valid=0, dump_last=0, dump_data=0, ovf=unf=0.
REQ-032 Reset mid-dump SHALL abort the dump with no further transfers.

Configuration
REQ-033 Macro STACK_DUMP_FLAGS_EN defined: ovf sets on REQ-021 event, unf sets on REQ-022 event (pop with depth < popped count), both clear only by rst.
REQ-034 Macro undefined: ovf and unf tied 0, no flag logic; all other behaviour identical.

Verification
REQ-035 Reset, push 0x1111,0x2222,0x3333 (we=1) -> rd1=0x3333, rd2=0x2222, depth=3.
REQ-036 From REQ-035 state, dump_req, dump_ready=1 -> data 0x3333,0x2222,0x1111 on three consecutive cycles, dump_last on third, busy drops next cycle.
REQ-037 Dump with dump_ready low 4 cycles mid-stream -> dump_data held, no skip/duplicate; push during SEND ignored, depth unchanged.
REQ-038 DEPTH=16: 17 pushes of 1..17 -> depth=16, dump yields 17 down to 2; ovf=1 with macro, 0 without.
REQ-039 depth=1, drop two -> depth=0, unf=1 (macro); dump_req then ignored, dump_busy stays 0.
REQ-040 Assert rst during SEND after 1 transfer -> dump_valid=0 same cycle, all outputs at reset values.
